sw_fpga_ctrl: RTL and testbench
===============================

Name: sw_fpga_ctrl

Overview:
Board-level sequencer between the push-buttons/switches and the Smith-Waterman FPGA wrapper. It debounces the set/start keys and issues single-cycle set-target and start-calculation pulses, only when the wrapper is idle. It latches scoring parameters for the duration of a run, captures the result on valid, and measures run latency. It also provides a selectable 32-bit value for the seven-segment display driver.

Parameters:
DB_LIMIT, 1_000_000, stable-level cycles before a key change is accepted (20 ms at 50 MHz)
DB_CNT_W, 20, debounce counter width (must hold DB_LIMIT-1)
TIMEOUT_CYCLES, 32'hFFFF_FFFF, RUN cycles before ERR
RESULT_W, 18, wrapper result width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_key_set_n  in  1  raw set-target key, active-low, asynchronous
i_key_start_n  in  1  raw start key, active-low, asynchronous
i_sw_match / i_sw_mismatch / i_sw_alpha / i_sw_beta  in  4 each  raw scoring switches
i_disp_sel  in  2  display select
i_busy  in  1  wrapper busy
i_valid  in  1  wrapper result valid (1-cycle pulse)
i_result  in  RESULT_W  wrapper result
o_set_t  out  1  set-target pulse to wrapper
o_start_cal  out  1  start pulse to wrapper
o_match / o_mismatch / o_alpha / o_beta  out  4 each  latched scoring parameters
o_disp_value  out  32  display value
o_state  out  3  FSM state encoding
o_done  out  1  high in DONE
o_error  out  1  high in ERR

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; t_loaded=0; cycle_cnt=0; run_cnt=0; result register=0; debouncers stable=1 (released).
- Key path: 2-flop synchronizer, then debounce. The counter clears whenever the synced level equals the stable level. Otherwise it increments. On reaching DB_LIMIT-1 the stable level takes the new value. A press event is a 1-cycle pulse on a stable 1->0 transition. Release generates no event.
- Set and start press in the same cycle: set wins; start is dropped.
- FSM encodings: IDLE=0, SET_PULSE=1, SET_WAIT=2, START_PULSE=3, RUN=4, DONE=5, ERR=6.
- IDLE / DONE / ERR:
  - set press with i_busy=0 -> SET_PULSE.
  - start press with t_loaded=1 and i_busy=0 (IDLE/DONE only) -> START_PULSE.
  - all other presses are ignored.
- SET_PULSE: o_set_t=1 for exactly one cycle -> SET_WAIT.
- SET_WAIT:
  - wait for i_busy=0, sampled no earlier than 2 cycles after the pulse.
  - then t_loaded=1 -> IDLE.
  - presses are ignored.
- START_PULSE:
  - in this same cycle, latch the switches into o_match..o_beta; they stay stable until the next START_PULSE.
  - o_start_cal=1 for one cycle; cycle_cnt cleared to 0 -> RUN.
- RUN:
  - cycle_cnt increments each cycle and saturates at 2^32-1.
  - i_valid=1 -> capture i_result, run_cnt+1 (16-bit, wraps) -> DONE.
  - cycle_cnt == TIMEOUT_CYCLES-1 without valid -> ERR.
  - i_valid and timeout in the same cycle: valid wins.
  - key presses are ignored.
- i_valid outside RUN: ignored; no capture.
- ERR: o_error=1; t_loaded forced to 0; only a set press (or reset) leaves ERR.
- o_done=1 exactly while in DONE.
- Display value: o_disp_value is registered (1-cycle latency from i_disp_sel or source change).
  - 0: zero-extended result.
  - 1: cycle_cnt.
  - 2: {16'b0, match, mismatch, alpha, beta} (latched parameters).
  - 3: {13'b0, state[2:0], run_cnt[15:0]}.
- Reset mid-RUN: immediate return to reset values; no pulse is emitted on release.

Decomposition:
- Package sw_ctrl_pkg holds:
  - typedef enum logic[2:0] ctrl_state_t (encodings above);
  - display-select localparams DISP_RESULT=0, DISP_CYCLES=1, DISP_PARAMS=2, DISP_STATUS=3;
  - SCORE_W=4.
- One sub-module, sw_key_debounce (params DB_LIMIT, DB_CNT_W; ports clk, rst_n, i_key_n, o_press), instantiated twice.

Test Plan:
All tests use DB_LIMIT=4.
- Glitch rejection: i_key_set_n low for 3 cycles, then high -> no o_set_t. Low for 10 cycles -> exactly one o_set_t pulse, state returns to IDLE after i_busy drops, and t_loaded=1.
- Start before set: after reset, press start -> no o_start_cal; state stays 0.
- Full run:
  - Stimulus: set (busy 5 cycles), then switches 4'h3/4'h1/4'h2/4'h1, then start; i_valid with i_result=18'h0_00A5 20 cycles after the start pulse.
  - Expected: o_done=1; disp_sel=0 gives 32'h0000_00A5; disp_sel=1 gives 20; disp_sel=2 gives 32'h0000_3121.
- Parameter hold: change the switches during RUN -> o_match..o_beta unchanged. A press during RUN produces no pulse.
- Timeout: TIMEOUT_CYCLES=50, no i_valid -> ERR at cycle 50 with o_error=1. Start press ignored; set press -> SET_PULSE.
- Reset mid-run: assert rst_n=0 in RUN -> all outputs 0 asynchronously; after release, state=IDLE and t_loaded=0.

Source files
------------

// File: rtl/sw_ctrl_pkg.sv
// Shared types and constants for the Smith-Waterman board sequencer.
// Holds the FSM state encoding, display-select codes and scoring-parameter layout.
package sw_ctrl_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SET_PULSE   = 3'd1,
    ST_SET_WAIT    = 3'd2,
    ST_START_PULSE = 3'd3,
    ST_RUN         = 3'd4,
    ST_DONE        = 3'd5,
    ST_ERR         = 3'd6
  } ctrl_state_t;

  localparam logic [1:0] DISP_RESULT = 2'd0;
  localparam logic [1:0] DISP_CYCLES = 2'd1;
  localparam logic [1:0] DISP_PARAMS = 2'd2;
  localparam logic [1:0] DISP_STATUS = 2'd3;

  typedef struct packed {
    logic [SCORE_W-1:0] match;
    logic [SCORE_W-1:0] mismatch;
    logic [SCORE_W-1:0] alpha;
    logic [SCORE_W-1:0] beta;
  } score_params_t;

endpackage

// File: rtl/sw_key_debounce.sv
// Active-low push-button conditioner: 2-flop synchronizer, level debounce,
// and a single-cycle press pulse on an accepted released->pressed transition.
module sw_key_debounce
  import sw_ctrl_pkg::*;
#(
  parameter int DB_LIMIT = 1_000_000,
  parameter int DB_CNT_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DB_LIMIT - 1);

  logic [1:0]          sync_q;
  logic                stable_q;
  logic [DB_CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments and resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      o_press  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_key_n};
      o_press <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        // Levels differ here, so an old stable of 1 means the key went down.
        o_press  <= stable_q;
      end else begin
        cnt_q <= cnt_q + DB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sw_fpga_ctrl.sv
// Board sequencer for the Smith-Waterman wrapper: key-driven set/start pulses,
// run parameter latching, result capture, latency counting and display select.
module sw_fpga_ctrl
  import sw_ctrl_pkg::*;
#(
  parameter int          DB_LIMIT       = 1_000_000,
  parameter int          DB_CNT_W       = 20,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF,
  parameter int          RESULT_W       = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_key_set_n,
  input  logic                i_key_start_n,
  input  logic [SCORE_W-1:0]  i_sw_match,
  input  logic [SCORE_W-1:0]  i_sw_mismatch,
  input  logic [SCORE_W-1:0]  i_sw_alpha,
  input  logic [SCORE_W-1:0]  i_sw_beta,
  input  logic [1:0]          i_disp_sel,
  input  logic                i_busy,
  input  logic                i_valid,
  input  logic [RESULT_W-1:0] i_result,
  output logic                o_set_t,
  output logic                o_start_cal,
  output logic [SCORE_W-1:0]  o_match,
  output logic [SCORE_W-1:0]  o_mismatch,
  output logic [SCORE_W-1:0]  o_alpha,
  output logic [SCORE_W-1:0]  o_beta,
  output logic [31:0]         o_disp_value,
  output logic [2:0]          o_state,
  output logic                o_done,
  output logic                o_error
);

  ctrl_state_t         state_q, state_d;
  logic                set_press, start_press;
  logic                t_loaded_q;
  logic                wait_q;
  logic [31:0]         cycle_cnt_q;
  logic [15:0]         run_cnt_q;
  logic [RESULT_W-1:0] result_q;
  score_params_t       params_q;
  logic [31:0]         disp_d, disp_q;
  logic                timeout_hit;

  sw_key_debounce #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_db_set (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (i_key_set_n),
    .o_press (set_press)
  );

  sw_key_debounce #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_db_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (i_key_start_n),
    .o_press (start_press)
  );

  assign timeout_hit = (cycle_cnt_q == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (set_press && !i_busy)
          state_d = ST_SET_PULSE;
        else if (start_press && !set_press && t_loaded_q && !i_busy)
          state_d = ST_START_PULSE;
      end
      ST_ERR:         if (set_press && !i_busy) state_d = ST_SET_PULSE;
      ST_SET_PULSE:   state_d = ST_SET_WAIT;
      // wait_q masks the first SET_WAIT cycle so busy is sampled two cycles after the pulse.
      ST_SET_WAIT:    if (wait_q && !i_busy) state_d = ST_IDLE;
      ST_START_PULSE: state_d = ST_RUN;
      ST_RUN: begin
        if (i_valid)          state_d = ST_DONE;
        else if (timeout_hit) state_d = ST_ERR;
      end
      default:        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_set_t     = 1'b0;
    o_start_cal = 1'b0;
    o_done      = 1'b0;
    o_error     = 1'b0;
    o_state     = state_q;
    case (state_q)
      ST_SET_PULSE:   o_set_t     = 1'b1;
      ST_START_PULSE: o_start_cal = 1'b1;
      ST_DONE:        o_done      = 1'b1;
      ST_ERR:         o_error     = 1'b1;
      default:        ;
    endcase
  end

  always_comb begin
    disp_d = '0;
    case (i_disp_sel)
      DISP_RESULT: disp_d = 32'(result_q);
      DISP_CYCLES: disp_d = cycle_cnt_q;
      DISP_PARAMS: disp_d = {16'b0, params_q};
      DISP_STATUS: disp_d = {13'b0, state_q, run_cnt_q};
      default:     disp_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_loaded_q  <= 1'b0;
      wait_q      <= 1'b0;
      cycle_cnt_q <= '0;
      run_cnt_q   <= '0;
      result_q    <= '0;
      params_q    <= '0;
      disp_q      <= '0;
    end else begin
      wait_q <= (state_q == ST_SET_WAIT);
      disp_q <= disp_d;

      if (state_d == ST_ERR)
        t_loaded_q <= 1'b0;
      else if (state_q == ST_SET_WAIT && state_d == ST_IDLE)
        t_loaded_q <= 1'b1;

      if (state_q == ST_START_PULSE) begin
        params_q    <= '{match: i_sw_match, mismatch: i_sw_mismatch,
                         alpha: i_sw_alpha, beta: i_sw_beta};
        cycle_cnt_q <= '0;
      end

      if (state_q == ST_RUN) begin
        if (cycle_cnt_q != 32'hFFFF_FFFF) cycle_cnt_q <= cycle_cnt_q + 32'd1;
        if (i_valid) begin
          result_q  <= i_result;
          run_cnt_q <= run_cnt_q + 16'd1;
        end
      end
    end
  end

  assign o_match      = params_q.match;
  assign o_mismatch   = params_q.mismatch;
  assign o_alpha      = params_q.alpha;
  assign o_beta       = params_q.beta;
  assign o_disp_value = disp_q;

endmodule

// File: tb/tb_sw_fpga_ctrl.sv
// Scoreboard bench for sw_fpga_ctrl: a behavioural model predicts wrapper-facing
// events and display values; a monitor pops expectations as the DUT emits events.
module tb_sw_fpga_ctrl;

  typedef enum int {EV_SET, EV_START, EV_DONE, EV_ERR} ev_t;
  typedef enum int {M_IDLE, M_RUN, M_DONE, M_ERR} mode_t;
  typedef struct {
    ev_t         kind;
    logic [15:0] params;
  } exp_t;

  logic        clk, rst_n;
  logic        i_key_set_n, i_key_start_n;
  logic [3:0]  i_sw_match, i_sw_mismatch, i_sw_alpha, i_sw_beta;
  logic [1:0]  i_disp_sel;
  logic        i_busy, i_valid;
  logic [17:0] i_result;
  logic        o_set_t, o_start_cal, o_done, o_error;
  logic [3:0]  o_match, o_mismatch, o_alpha, o_beta;
  logic [31:0] o_disp_value;
  logic [2:0]  o_state;

  int   n_vec = 0;
  int   n_err = 0;
  int   g_busy_len = 0;
  exp_t sb_q[$];

  mode_t       m_mode;
  bit          m_loaded;
  logic [17:0] m_result;
  int          m_cycles;
  logic [15:0] m_run_cnt;
  logic [15:0] m_params;

  sw_fpga_ctrl #(
    .DB_LIMIT       (4),
    .DB_CNT_W       (2),
    .TIMEOUT_CYCLES (32'd50),
    .RESULT_W       (18)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_key_set_n   (i_key_set_n),
    .i_key_start_n (i_key_start_n),
    .i_sw_match    (i_sw_match),
    .i_sw_mismatch (i_sw_mismatch),
    .i_sw_alpha    (i_sw_alpha),
    .i_sw_beta     (i_sw_beta),
    .i_disp_sel    (i_disp_sel),
    .i_busy        (i_busy),
    .i_valid       (i_valid),
    .i_result      (i_result),
    .o_set_t       (o_set_t),
    .o_start_cal   (o_start_cal),
    .o_match       (o_match),
    .o_mismatch    (o_mismatch),
    .o_alpha       (o_alpha),
    .o_beta        (o_beta),
    .o_disp_value  (o_disp_value),
    .o_state       (o_state),
    .o_done        (o_done),
    .o_error       (o_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_set_t, o_start_cal, o_match, o_mismatch, o_alpha, o_beta,
                o_disp_value, o_state, o_done, o_error});
  endfunction

  function automatic logic [2:0] state_code();
    case (m_mode)
      M_RUN:   return 3'd4;
      M_DONE:  return 3'd5;
      M_ERR:   return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] disp_expect(input int sel);
    case (sel)
      0:       return {14'b0, m_result};
      1:       return 32'(m_cycles);
      2:       return {16'b0, m_params};
      default: return {13'b0, state_code(), m_run_cnt};
    endcase
  endfunction

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_loaded  = 1'b0;
    m_result  = '0;
    m_cycles  = 0;
    m_run_cnt = '0;
    m_params  = '0;
  endtask

  // Wrapper stand-in: holds busy high for g_busy_len cycles from each set pulse.
  initial begin
    i_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (o_set_t === 1'b1 && g_busy_len > 0) begin
        i_busy = 1'b1;
        repeat (g_busy_len) begin
          @(posedge clk);
          #1;
        end
        i_busy = 1'b0;
      end
    end
  end

  task automatic sb_pop(input ev_t kind);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL unexpected_event: got event %0d, expected no event", kind);
    end else begin
      e = sb_q.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      if (kind == EV_DONE || kind == EV_ERR)
        check("event_params", 64'({o_match, o_mismatch, o_alpha, o_beta}), 64'(e.params));
    end
  endtask

  initial begin
    logic done_d = 1'b0;
    logic err_d  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (o_set_t === 1'b1)               sb_pop(EV_SET);
        if (o_start_cal === 1'b1)           sb_pop(EV_START);
        if (o_done === 1'b1 && !done_d)     sb_pop(EV_DONE);
        if (o_error === 1'b1 && !err_d)     sb_pop(EV_ERR);
      end
      done_d = o_done;
      err_d  = o_error;
    end
  end

  // Holds a key low for len cycles and watches up to 14 cycles for its pulse.
  task automatic press(input bit is_set, input int len, input bit want, output bit seen);
    seen = 1'b0;
    tick(8);
    if (is_set) i_key_set_n = 1'b0;
    else        i_key_start_n = 1'b0;
    for (int k = 1; k <= 14 && !seen; k++) begin
      tick();
      if (k == len) begin
        i_key_set_n   = 1'b1;
        i_key_start_n = 1'b1;
      end
      if ((is_set ? o_set_t : o_start_cal) === 1'b1) seen = 1'b1;
    end
    i_key_set_n   = 1'b1;
    i_key_start_n = 1'b1;
    check(is_set ? "set_pulse_seen" : "start_pulse_seen", 64'(seen), 64'(want));
  endtask

  task automatic do_set(input int busy_len);
    bit want, seen;
    int idle_at;
    want = (m_mode != M_RUN);
    if (want) sb_q.push_back('{EV_SET, 16'h0});
    g_busy_len = busy_len;
    press(1'b1, 6, want, seen);
    if (seen) begin
      check("set_pulse_state", 64'(o_state), 64'(1));
      idle_at = (busy_len < 2) ? 3 : busy_len + 1;
      tick(idle_at - 1);
      check("set_wait_hold", 64'(o_state), 64'(2));
      tick();
      check("set_wait_exit", 64'(o_state), 64'(0));
      m_loaded = 1'b1;
      m_mode   = M_IDLE;
    end
  endtask

  task automatic do_start(output bit seen);
    bit want;
    want = (m_mode == M_IDLE || m_mode == M_DONE) && m_loaded;
    if (want) sb_q.push_back('{EV_START, 16'h0});
    press(1'b0, 6, want, seen);
    if (seen) m_mode = M_RUN;
  endtask

  task automatic check_display();
    for (int s = 0; s < 4; s++) begin
      i_disp_sel = 2'(s);
      tick();
      check($sformatf("disp_sel_%0d", s), 64'(o_disp_value), 64'(disp_expect(s)));
    end
  endtask

  // L = cycles from start pulse to i_valid; L = 0 lets the run time out.
  task automatic do_run(input int L, input logic [17:0] res, input logic [15:0] sw,
                        input bit chg_sw, input bit key_in_run);
    bit   seen;
    int   last;
    logic [15:0] junk;
    {i_sw_match, i_sw_mismatch, i_sw_alpha, i_sw_beta} = sw;
    do_start(seen);
    if (!seen) return;
    m_params = sw;
    if (L == 0) sb_q.push_back('{EV_ERR, sw});
    last = (L == 0) ? 51 : L;
    for (int k = 1; k <= last; k++) begin
      tick();
      if (chg_sw && k == 2) begin
        junk = 16'($urandom);
        {i_sw_match, i_sw_mismatch, i_sw_alpha, i_sw_beta} = junk;
      end
      if (key_in_run && k == 1) i_key_set_n = 1'b0;
      if (key_in_run && k == 7) i_key_set_n = 1'b1;
      if (L == 0 && k == 50) check("run_before_timeout", 64'(o_state), 64'(4));
      if (L > 0 && k == L) begin
        i_valid  = 1'b1;
        i_result = res;
        sb_q.push_back('{EV_DONE, sw});
      end
    end
    if (L > 0) begin
      tick();
      i_valid   = 1'b0;
      i_result  = 18'($urandom);
      m_result  = res;
      m_cycles  = L;
      m_run_cnt = m_run_cnt + 16'd1;
      m_mode    = M_DONE;
    end else begin
      m_cycles = 50;
      m_mode   = M_ERR;
      m_loaded = 1'b0;
    end
    check("state_after_run", 64'(o_state), 64'(state_code()));
    check("done_flag", 64'(o_done), 64'(m_mode == M_DONE));
    check("error_flag", 64'(o_error), 64'(m_mode == M_ERR));
    check("params_held", 64'({o_match, o_mismatch, o_alpha, o_beta}), 64'(m_params));
    check_display();
  endtask

  initial begin
    bit          seen;
    int          L;
    logic [17:0] res;
    logic [15:0] sw;

    rst_n = 1'b0;
    i_key_set_n = 1'b1;
    i_key_start_n = 1'b1;
    {i_sw_match, i_sw_mismatch, i_sw_alpha, i_sw_beta} = 16'h0;
    i_disp_sel = 2'd0;
    i_valid = 1'b0;
    i_result = '0;
    model_reset();

    tick(3);
    check("reset_outputs", all_outs(), 64'(0));
    rst_n = 1'b1;
    tick(2);
    check("reset_state", 64'(o_state), 64'(0));
    check_display();

    // Start with no target loaded is ignored; a 3-cycle glitch on set is rejected.
    do_start(seen);
    check("start_before_set", 64'(o_state), 64'(0));
    press(1'b1, 3, 1'b0, seen);
    check("glitch_state", 64'(o_state), 64'(0));

    do_set(0);
    do_set(5);
    do_run(20, 18'h000A5, 16'h3121, 1'b1, 1'b1);

    // i_valid outside RUN must not disturb the captured result.
    i_disp_sel = 2'd0;
    i_valid  = 1'b1;
    i_result = 18'h3_1234;
    tick();
    i_valid = 1'b0;
    tick();
    check("valid_outside_run", 64'(o_disp_value), 64'(disp_expect(0)));

    // Valid arriving on the timeout cycle wins.
    res = 18'($urandom);
    sw  = 16'($urandom);
    do_run(50, res, sw, 1'b0, 1'b1);

    // Timeout into ERR, start ignored there, set leaves it.
    sw = 16'($urandom);
    do_run(0, 18'h0, sw, 1'b1, 1'b0);
    do_start(seen);
    check("err_ignores_start", 64'(o_state), 64'(6));
    do_set(2);
    do_run(7, 18'h2_5A5A, 16'hF0E1, 1'b0, 1'b0);

    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 2) == 0) do_set(int'($urandom_range(0, 6)));
      L   = int'($urandom_range(1, 50));
      res = 18'($urandom);
      sw  = 16'($urandom);
      do_run(L, res, sw, 1'($urandom_range(0, 1)), (L >= 15) && ($urandom_range(0, 1) == 1));
    end

    // Reset in the middle of a run clears everything asynchronously.
    if (!m_loaded) do_set(1);
    sw = 16'($urandom) | 16'h1000;
    {i_sw_match, i_sw_mismatch, i_sw_alpha, i_sw_beta} = sw;
    i_disp_sel = 2'd1;
    do_start(seen);
    tick(6);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 64'(0));
    tick(2);
    rst_n = 1'b1;
    model_reset();
    tick(2);
    check("post_reset_state", 64'(o_state), 64'(0));
    do_start(seen);
    check("post_reset_unloaded", 64'(o_state), 64'(0));

    tick(4);
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
